// File: rtl/alu_sequencer.sv
// Multi-cycle micro-sequencer for the shared 16-bit ALU and register file.
// Runs one instruction at a time through IDLE -> READ -> EXEC -> WB and retires it on a write grant.
module alu_sequencer #(
  parameter int RF_AW      = 3,
  parameter int WB_TIMEOUT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Inst_Valid,
  input  logic [15:0]      Inst_In,
  output logic             Inst_Ready,
  output logic [RF_AW-1:0] Rd_Addr_A,
  output logic [RF_AW-1:0] Rd_Addr_B,
  output logic [5:0]       ALU_OP,
  output logic             Latch_Result,
  output logic             Latch_Flags,
  output logic             Wr_En,
  output logic [RF_AW-1:0] Wr_Addr,
  input  logic             Wr_Grant,
  output logic             Done,
  output logic             Err,
  output logic [CNT_W-1:0] Op_Count
);

  // Handshake: an instruction transfers on a rising edge where Inst_Valid && Inst_Ready;
  // Inst_Ready is only high in IDLE, and Inst_Valid/Inst_In are ignored otherwise.

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t           state, state_nxt;
  logic [15:0]      ir;
  logic [7:0]       to_cnt;
  logic [CNT_W-1:0] op_cnt;
  logic             timeout_hit;

  logic             ready_c, latch_res_c, latch_flg_c, wr_en_c, done_c, err_c;
  logic [RF_AW-1:0] addr_a_c, addr_b_c, wr_addr_c;
  logic [5:0]       alu_op_c;

  // Expires on the WB cycle that would bring the counter up to WB_TIMEOUT.
  assign timeout_hit = (({1'b0, to_cnt} + 9'd1) == 9'(WB_TIMEOUT));

  always_comb begin
    state_nxt   = state;
    ready_c     = 1'b0;
    latch_res_c = 1'b0;
    latch_flg_c = 1'b0;
    wr_en_c     = 1'b0;
    done_c      = 1'b0;
    err_c       = 1'b0;
    addr_a_c    = '0;
    addr_b_c    = '0;
    wr_addr_c   = '0;
    alu_op_c    = '0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (Inst_Valid) state_nxt = READ;
      end
      READ: begin
        addr_a_c  = RF_AW'(ir[6:4]);
        addr_b_c  = RF_AW'(ir[3:1]);
        alu_op_c  = ir[15:10];
        state_nxt = EXEC;
      end
      EXEC: begin
        addr_a_c    = RF_AW'(ir[6:4]);
        addr_b_c    = RF_AW'(ir[3:1]);
        alu_op_c    = ir[15:10];
        latch_res_c = 1'b1;
        latch_flg_c = ir[0];
        state_nxt   = WB;
      end
      WB: begin
        addr_a_c  = RF_AW'(ir[6:4]);
        addr_b_c  = RF_AW'(ir[3:1]);
        alu_op_c  = ir[15:10];
        wr_en_c   = 1'b1;
        wr_addr_c = RF_AW'(ir[9:7]);
        if (Wr_Grant) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          err_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      ir     <= '0;
      to_cnt <= '0;
      op_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Inst_Valid) ir <= Inst_In;
      if (state == EXEC) to_cnt <= '0;
      else if (state == WB && !Wr_Grant) to_cnt <= to_cnt + 8'd1;
      if (done_c) op_cnt <= op_cnt + 1'b1;
    end
  end

  // Outputs are forced low for as long as Reset is held, not just after the reset edge.
  assign Inst_Ready   = Reset & ready_c;
  assign Latch_Result = Reset & latch_res_c;
  assign Latch_Flags  = Reset & latch_flg_c;
  assign Wr_En        = Reset & wr_en_c;
  assign Done         = Reset & done_c;
  assign Err          = Reset & err_c;
  assign Rd_Addr_A    = Reset ? addr_a_c  : '0;
  assign Rd_Addr_B    = Reset ? addr_b_c  : '0;
  assign Wr_Addr      = Reset ? wr_addr_c : '0;
  assign ALU_OP       = Reset ? alu_op_c  : '0;
  assign Op_Count     = Reset ? op_cnt    : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: reset, single issue, flag strobe, WB stall,
// write timeout, mid-instruction reset and back-to-back issue with counter wrap.
module tb_alu_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Inst_Valid;
  logic [15:0] Inst_In;
  logic        Inst_Ready;
  logic [2:0]  Rd_Addr_A, Rd_Addr_B, Wr_Addr;
  logic [5:0]  ALU_OP;
  logic        Latch_Result, Latch_Flags, Wr_En, Wr_Grant, Done, Err;
  logic [3:0]  Op_Count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  exp_cnt = 4'd0;

  logic [5:0]  obs;
  logic [33:0] all_out;

  // Narrow counter so the wrap is reachable in a short run.
  alu_sequencer #(.RF_AW(3), .WB_TIMEOUT(15), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Inst_Valid(Inst_Valid), .Inst_In(Inst_In),
    .Inst_Ready(Inst_Ready), .Rd_Addr_A(Rd_Addr_A), .Rd_Addr_B(Rd_Addr_B),
    .ALU_OP(ALU_OP), .Latch_Result(Latch_Result), .Latch_Flags(Latch_Flags),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Grant(Wr_Grant), .Done(Done),
    .Err(Err), .Op_Count(Op_Count)
  );

  // obs = {Inst_Ready, Latch_Result, Latch_Flags, Wr_En, Done, Err}
  assign obs     = {Inst_Ready, Latch_Result, Latch_Flags, Wr_En, Done, Err};
  assign all_out = {Inst_Ready, Rd_Addr_A, Rd_Addr_B, ALU_OP, Latch_Result, Latch_Flags,
                    Wr_En, Wr_Addr, Done, Err, Op_Count};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      n_tests++;
      if (all_out !== 34'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, all_out);
      end
    end
    @(negedge Clk);
    Reset = 1'b1; Inst_Valid = 1'b0; #1;
    n_tests++;
    if (obs !== 6'b100000 || Op_Count !== 4'd0 || ALU_OP !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release: got obs=%b cnt=%0d op=%0d expected obs=100000 cnt=0 op=0",
               obs, Op_Count, ALU_OP);
    end
  endtask

  task automatic test_single(input logic [15:0] inst, input logic upd);
    @(negedge Clk);
    Inst_In = inst; Inst_Valid = 1'b1; Wr_Grant = 1'b1; #1;
    n_tests++;
    if (obs !== 6'b100000) begin
      n_fail++; $display("FAIL single_idle: got %b expected 100000", obs);
    end
    @(negedge Clk);
    Inst_Valid = 1'b0; Inst_In = 16'hFFFF; #1;
    n_tests++;
    if (obs !== 6'b000000 || ALU_OP !== 6'd2 || Rd_Addr_A !== 3'd5 || Rd_Addr_B !== 3'd5) begin
      n_fail++;
      $display("FAIL single_read: got obs=%b op=%0d a=%0d b=%0d expected 000000 2 5 5",
               obs, ALU_OP, Rd_Addr_A, Rd_Addr_B);
    end
    @(negedge Clk); #1;
    n_tests++;
    if (obs !== {2'b01, upd, 3'b000} || ALU_OP !== 6'd2) begin
      n_fail++;
      $display("FAIL single_exec: got obs=%b op=%0d expected %b 2", obs, ALU_OP, {2'b01, upd, 3'b000});
    end
    @(negedge Clk); #1;
    n_tests++;
    if (obs !== 6'b000110 || Wr_Addr !== 3'd4 || ALU_OP !== 6'd2) begin
      n_fail++;
      $display("FAIL single_wb: got obs=%b wa=%0d op=%0d expected 000110 4 2", obs, Wr_Addr, ALU_OP);
    end
    exp_cnt = exp_cnt + 4'd1;
    @(negedge Clk); #1;
    n_tests++;
    if (obs !== 6'b100000 || Op_Count !== exp_cnt || ALU_OP !== 6'd0) begin
      n_fail++;
      $display("FAIL single_retire: got obs=%b cnt=%0d op=%0d expected 100000 %0d 0",
               obs, Op_Count, ALU_OP, exp_cnt);
    end
  endtask

  task automatic test_wb_stall();
    @(negedge Clk);
    Inst_In = 16'hFC8E; Inst_Valid = 1'b1; Wr_Grant = 1'b0;
    @(negedge Clk);
    Inst_Valid = 1'b0; #1;
    n_tests++;
    if (ALU_OP !== 6'd63 || Rd_Addr_A !== 3'd0 || Rd_Addr_B !== 3'd7) begin
      n_fail++;
      $display("FAIL stall_read: got op=%0d a=%0d b=%0d expected 63 0 7", ALU_OP, Rd_Addr_A, Rd_Addr_B);
    end
    @(negedge Clk); #1;
    n_tests++;
    if (obs !== 6'b010000) begin
      n_fail++; $display("FAIL stall_exec: got %b expected 010000", obs);
    end
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      Wr_Grant = (i == 6); #1;
      n_tests++;
      if (obs !== {5'b00010, 1'b0} + {4'b0, (i == 6), 1'b0} || Wr_Addr !== 3'd1) begin
        n_fail++;
        $display("FAIL stall_wb cycle %0d: got obs=%b wa=%0d expected done=%0d wa=1",
                 i, obs, Wr_Addr, (i == 6));
      end
    end
    exp_cnt = exp_cnt + 4'd1;
    @(negedge Clk);
    Wr_Grant = 1'b0; #1;
    n_tests++;
    if (obs !== 6'b100000 || Op_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL stall_retire: got obs=%b cnt=%0d expected 100000 %0d", obs, Op_Count, exp_cnt);
    end
  endtask

  task automatic test_timeout(input logic grant_last);
    logic done_e, err_e;
    @(negedge Clk);
    Inst_In = 16'h0A5B; Inst_Valid = 1'b1; Wr_Grant = 1'b0;
    @(negedge Clk);
    Inst_Valid = 1'b0;
    @(negedge Clk);
    for (int i = 1; i <= 15; i++) begin
      @(negedge Clk);
      done_e   = grant_last && (i == 15);
      err_e    = !grant_last && (i == 15);
      Wr_Grant = done_e; #1;
      n_tests++;
      if (obs !== {3'b000, 1'b1, done_e, err_e}) begin
        n_fail++;
        $display("FAIL timeout_wb(grant_last=%0b) cycle %0d: got %b expected %b",
                 grant_last, i, obs, {3'b000, 1'b1, done_e, err_e});
      end
    end
    if (grant_last) exp_cnt = exp_cnt + 4'd1;
    @(negedge Clk);
    Wr_Grant = 1'b0; #1;
    n_tests++;
    if (obs !== 6'b100000 || Op_Count !== exp_cnt) begin
      n_fail++;
      $display("FAIL timeout_after(grant_last=%0b): got obs=%b cnt=%0d expected 100000 %0d",
               grant_last, obs, Op_Count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    Inst_In = 16'h0A5B; Inst_Valid = 1'b1; Wr_Grant = 1'b0;
    @(negedge Clk);
    Inst_Valid = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0; Inst_Valid = 1'b1; #1;
    n_tests++;
    if (all_out !== 34'd0) begin
      n_fail++; $display("FAIL reset_mid_hold: got %h expected 0", all_out);
    end
    @(negedge Clk);
    Reset = 1'b1; Inst_Valid = 1'b0; #1;
    exp_cnt = 4'd0;
    n_tests++;
    if (obs !== 6'b100000 || Op_Count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_release: got obs=%b cnt=%0d expected 100000 0", obs, Op_Count);
    end
    @(negedge Clk); #1;
    n_tests++;
    if (obs !== 6'b100000) begin
      n_fail++; $display("FAIL reset_mid_quiet: got %b expected 100000", obs);
    end
  endtask

  task automatic test_back_to_back();
    int  n_done;
    logic [5:0] exp_obs;
    n_done = 0;
    @(negedge Clk);
    Inst_In = 16'h0A5B; Inst_Valid = 1'b1; Wr_Grant = 1'b1;
    for (int c = 0; c < 100 && n_done < 15; c++) begin
      if (c > 0) @(negedge Clk);
      #1;
      if (Done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done != 15) begin
      n_fail++; $display("FAIL b2b_preload: got %0d retirements expected 15", n_done);
    end
    exp_cnt = 4'd15;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk); #1;
      case (c % 4)
        0:       exp_obs = 6'b100000;
        1:       exp_obs = 6'b000000;
        2:       exp_obs = 6'b011000;
        default: exp_obs = 6'b000110;
      endcase
      n_tests++;
      if (obs !== exp_obs || (c % 4 == 0 && Op_Count !== exp_cnt)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: got obs=%b cnt=%0d expected %b %0d", c, obs, Op_Count, exp_obs, exp_cnt);
      end
      if (c % 4 == 3) exp_cnt = exp_cnt + 4'd1;
    end
    @(negedge Clk);
    Inst_Valid = 1'b0; #1;
    n_tests++;
    if (obs !== 6'b100000 || Op_Count !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_wrap: got obs=%b cnt=%0d expected 100000 1", obs, Op_Count);
    end
  endtask

  initial begin
    Reset = 1'b0; Inst_Valid = 1'b1; Inst_In = 16'h0A5B; Wr_Grant = 1'b1;
    test_reset();
    test_single(16'h0A5B, 1'b1);
    test_single(16'h0A5A, 1'b0);
    test_wb_stall();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
